fe_mul_arbiter: RTL and testbench
=================================

# fe_mul_arbiter

Shares one `fe_mulx` field-element multiplier between N independent requesters, such as `ge_frombytes_negate_vartime` and the group-operation sequencers. The block captures one-cycle request pulses into per-port slots and grants the multiplier round-robin. It drives the `mul_op_a` / `mul_op_b` / `mul_valid` / `mul_res` / `mul_done` handshake and returns each result to the issuing port. It sits between the requester modules and the single `fe_mulx` instance in the top level.

## Interface
- `N`, default 2: number of requester ports (2..8).
- `FE_W`, default 320: field-element width (10 limbs × 32 b).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_op_a` in N*FE_W: port i operand A at bits [i*FE_W +: FE_W].
- `req_op_b` in N*FE_W: port i operand B, same packing.
- `req_valid` in N: one-cycle request pulse per port.
- `req_busy` out N: port i has a request pending or in service.
- `req_done` out N: one-hot, one-cycle completion pulse.
- `req_res` out FE_W: product of the most recent completion; shared by all ports and held until the next completion.
- `mul_op_a` out FE_W: operand A to `fe_mulx`.
- `mul_op_b` out FE_W: operand B to `fe_mulx`.
- `mul_valid` out 1: start pulse to `fe_mulx`.
- `mul_res` in FE_W: product from `fe_mulx`.
- `mul_done` in 1: completion pulse from `fe_mulx`.
- `error` out 1: sticky protocol-violation flag, cleared only by `rst`.

## Operation
- **Capture.** If `req_valid[i]` is high and `pending[i]` is 0, the slot latches `req_op_a[i]` and `req_op_b[i]` and sets `pending[i]`.
  - `req_busy` equals `pending`.
  - A valid pulse on a busy port is dropped and sets `error`.
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE: if any `pending` bit is set, `grant` becomes the first pending port scanning upward from `last_grant+1` (mod N), and the FSM moves to ISSUE. Otherwise it stays in IDLE.
  - ISSUE: `mul_valid`=1 for exactly this cycle, then move to WAIT.
  - WAIT: hold operands stable. On `mul_done`: register `req_res`←`mul_res`, `req_done[grant]`←1 (visible the next cycle), clear `pending[grant]`, set `last_grant`←`grant`, return to IDLE.
- `mul_op_a` and `mul_op_b` are always the slot contents of `grant`. They stay stable from ISSUE through the `mul_done` cycle.
- Only one multiply is outstanding at any time.
- `mul_done` seen outside WAIT is ignored and sets `error`.
- A port may re-request in the cycle its `req_done` is high, because `pending` is already clear.
- **Reset values:**
  - state=IDLE, `pending`=0, `grant`=0, `last_grant`=N-1 (port 0 wins first), slots=0.
  - Outputs: `mul_op_a`/`mul_op_b`=0, `mul_valid`=0, `req_done`=0, `req_res`=0, `req_busy`=0, `error`=0.
- **Reset mid-operation** discards all pending and in-flight requests; no `req_done` is issued for them. `fe_mulx` shares `rst`, so it aborts too.

## Timing
- Valid sampled at edge E0 → arbitration in cycle 1 → `mul_valid` high in cycle 2.
- `mul_done` in cycle D → `req_done` and `req_res` valid in cycle D+1. The next grant may issue `mul_valid` in cycle D+2.
- Fixed overhead: 3 cycles per request beyond the multiplier latency.
- When requests are contended, the wait per port is at most N-1 multiply services.
- Simultaneous valids on several ports in one cycle are all captured and served in round-robin order.

## Structure
- `FE_W` and the limb count belong in the shared field-element include (`fe_common.v`), alongside `fe_add` and `fe_sub`.
- One natural sub-module: `rr_arbiter`, a combinational N-way round-robin pick from (`pending`, `last_grant`) that outputs a one-hot grant and a valid bit.
- The top level instantiates one `fe_mulx` and this arbiter. Requesters connect their `mul_*` ports to `req_*` slices.

## Test plan
- **Single request:** port 0 sends A=0x…02, B=0x…03 → exactly one `mul_valid`; `req_done`=01 in cycle D+1; `req_res` = `fe_mulx`(A,B); `error`=0.
- **Simultaneous request:** ports 0 and 1 pulse valid in the same cycle → port 0 is served first, then port 1. Two `req_done` pulses (01, then 10), each result matching its own operands.
- **Fairness:** port 0 re-requests immediately on every `req_done` while port 1 stays pending → grants alternate 0,1,0,1 and port 1 is never skipped.
- **Busy violation:** port 1 pulses valid again while `req_busy[1]`=1 → the second pulse is dropped, only one `req_done[1]` occurs, and `error` rises and stays 1.
- **Reset during WAIT:** assert `rst` mid-multiply → all outputs go to their reset values asynchronously, no `req_done` appears afterwards, and a new request after reset completes normally.
- **Spurious `mul_done`:** force `mul_done` while in IDLE → no `req_done` and `error`=1.

Source files
------------

// File: rtl/fe_mul_arbiter_pkg.sv
// Shared constants and types for the fe_mulx request arbiter.
// The field-element geometry matches the 10 x 32-bit limb layout used by fe_add/fe_sub.
package fe_mul_arbiter_pkg;

  localparam int FE_LIMBS     = 10;
  localparam int FE_LIMB_W    = 32;
  localparam int FE_W_DEFAULT = FE_LIMBS * FE_LIMB_W;
  localparam int N_MAX        = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_t;

  // Port-index width; never zero so a 1-port build still has a legal index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fe_mul_arbiter_if.sv
// Handshake bundle between the arbiter (master) and the single fe_mulx instance (slave).
interface fe_mul_if
  import fe_mul_arbiter_pkg::*;
#(
  parameter int FE_W = FE_W_DEFAULT
);

  logic [FE_W-1:0] mul_op_a;
  logic [FE_W-1:0] mul_op_b;
  logic            mul_valid;
  logic [FE_W-1:0] mul_res;
  logic            mul_done;

  modport master (
    output mul_op_a,
    output mul_op_b,
    output mul_valid,
    input  mul_res,
    input  mul_done
  );

  modport slave (
    input  mul_op_a,
    input  mul_op_b,
    input  mul_valid,
    output mul_res,
    output mul_done
  );

endinterface

// File: rtl/fe_mul_arbiter_rr_arbiter.sv
// Combinational N-way round-robin pick: first pending port scanning upward from last_grant+1.
module rr_arbiter
  import fe_mul_arbiter_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant_oh,
  output logic             grant_valid
);

  always_comb begin
    grant_oh    = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!grant_valid && pending[(int'(last_grant) + k) % N]) begin
        grant_oh[(int'(last_grant) + k) % N] = 1'b1;
        grant_valid                          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fe_mul_arbiter.sv
// Shares one fe_mulx between N requesters: captures request pulses into per-port slots,
// grants round-robin, and returns each product with a one-hot done pulse.
module fe_mul_arbiter
  import fe_mul_arbiter_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int FE_W  = FE_W_DEFAULT,
  localparam int IDX_W = idx_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*FE_W-1:0] req_op_a,
  input  logic [N*FE_W-1:0] req_op_b,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_busy,
  output logic [N-1:0]      req_done,
  output logic [FE_W-1:0]   req_res,
  fe_mul_if.master          mul,
  output logic              error
);

  arb_state_t       state;
  logic [N-1:0]     pending;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] next_grant;
  logic [N-1:0]     grant_oh;
  logic             grant_valid;
  logic             mul_valid_q;
  logic [FE_W-1:0]  slot_a [N];
  logic [FE_W-1:0]  slot_b [N];

  rr_arbiter #(.N(N)) u_rr (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_oh    (grant_oh),
    .grant_valid (grant_valid)
  );

  always_comb begin
    next_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) next_grant = IDX_W'(i);
    end
  end

  // A slot cannot be rewritten while pending, so the operands stay stable until mul_done.
  assign mul.mul_op_a  = slot_a[grant];
  assign mul.mul_op_b  = slot_b[grant];
  assign mul.mul_valid = mul_valid_q;
  assign req_busy      = pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      grant       <= '0;
      last_grant  <= IDX_W'(N - 1);
      mul_valid_q <= 1'b0;
      req_done    <= '0;
      req_res     <= '0;
      error       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        slot_a[i] <= '0;
        slot_b[i] <= '0;
      end
    end else begin
      req_done    <= '0;
      mul_valid_q <= 1'b0;

      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (pending[i]) begin
            error <= 1'b1;
          end else begin
            slot_a[i]  <= req_op_a[i*FE_W +: FE_W];
            slot_b[i]  <= req_op_b[i*FE_W +: FE_W];
            pending[i] <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            grant       <= next_grant;
            mul_valid_q <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (mul.mul_done) begin
            req_res         <= mul.mul_res;
            req_done[grant] <= 1'b1;
            pending[grant]  <= 1'b0;
            last_grant      <= grant;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Only one multiply is ever outstanding, so a done outside WAIT is a protocol fault.
      if (mul.mul_done && (state != ST_WAIT)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Directed bench for fe_mul_arbiter with a fixed-latency behavioural multiplier on the slave side.
module tb_fe_mul_arbiter;

  localparam int N    = 2;
  localparam int FE_W = 320;
  localparam int LAT  = 2;

  logic              clk;
  logic              rst;
  logic [N*FE_W-1:0] req_op_a;
  logic [N*FE_W-1:0] req_op_b;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_busy;
  logic [N-1:0]      req_done;
  logic [FE_W-1:0]   req_res;
  logic              error;

  fe_mul_if #(.FE_W(FE_W)) mul_bus ();

  fe_mul_arbiter #(.N(N), .FE_W(FE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_op_a  (req_op_a),
    .req_op_b  (req_op_b),
    .req_valid (req_valid),
    .req_busy  (req_busy),
    .req_done  (req_done),
    .req_res   (req_res),
    .mul       (mul_bus),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural multiplier: product truncated to FE_W, done LAT+1 cycles after the start pulse.
  logic [FE_W-1:0] m_a, m_b, m_res;
  logic            m_done;
  logic            force_done;
  int              m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_a    <= '0;
      m_b    <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_bus.mul_valid) begin
        m_a   <= mul_bus.mul_op_a;
        m_b   <= mul_bus.mul_op_b;
        m_cnt <= LAT;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res  <= m_a * m_b;
        end
      end
    end
  end

  assign mul_bus.mul_done = m_done | force_done;
  assign mul_bus.mul_res  = m_res;

  // Event log of completions and start pulses.
  logic [N-1:0]    done_q [$];
  logic [FE_W-1:0] res_q  [$];
  int              valid_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_bus.mul_valid) valid_cnt++;
      if (req_done != '0) begin
        done_q.push_back(req_done);
        res_q.push_back(req_res);
      end
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string tag, input logic [FE_W-1:0] got, input logic [FE_W-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask,
                               input logic [FE_W-1:0] a0, input logic [FE_W-1:0] b0,
                               input logic [FE_W-1:0] a1, input logic [FE_W-1:0] b1);
    @(negedge clk);
    req_op_a  = {a1, a0};
    req_op_b  = {b1, b0};
    req_valid = mask;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic waitForDone(input string tag, input int n, input int budget);
    int cyc = 0;
    while (done_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, FE_W'(done_q.size() >= n), FE_W'(1));
  endtask

  task automatic clearLog();
    done_q.delete();
    res_q.delete();
    valid_cnt = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearLog();
  endtask

  int seen;

  initial begin
    rst        = 1'b1;
    req_op_a   = '0;
    req_op_b   = '0;
    req_valid  = '0;
    force_done = 1'b0;
    valid_cnt  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clearLog();

    $display("[TB] reset values");
    checkOutput("rst_busy",  FE_W'(req_busy), FE_W'(0));
    checkOutput("rst_done",  FE_W'(req_done), FE_W'(0));
    checkOutput("rst_res",   req_res, FE_W'(0));
    checkOutput("rst_error", FE_W'(error), FE_W'(0));
    checkOutput("rst_valid", FE_W'(mul_bus.mul_valid), FE_W'(0));
    checkOutput("rst_op_a",  mul_bus.mul_op_a, FE_W'(0));

    $display("[TB] single request on port 0");
    applyStimulus(2'b01, FE_W'(2), FE_W'(3), FE_W'(0), FE_W'(0));
    checkOutput("single_busy_c1",  FE_W'(req_busy), FE_W'(1));
    checkOutput("single_valid_c1", FE_W'(mul_bus.mul_valid), FE_W'(0));
    @(negedge clk);
    checkOutput("single_valid_c2", FE_W'(mul_bus.mul_valid), FE_W'(1));
    checkOutput("single_op_a",     mul_bus.mul_op_a, FE_W'(2));
    checkOutput("single_op_b",     mul_bus.mul_op_b, FE_W'(3));
    waitForDone("single_timeout", 1, 50);
    repeat (3) @(negedge clk);
    checkOutput("single_done",     FE_W'(done_q[0]), FE_W'(2'b01));
    checkOutput("single_res",      res_q[0], FE_W'(6));
    checkOutput("single_ndone",    FE_W'(done_q.size()), FE_W'(1));
    checkOutput("single_nvalid",   FE_W'(valid_cnt), FE_W'(1));
    checkOutput("single_busy_end", FE_W'(req_busy), FE_W'(0));
    checkOutput("single_error",    FE_W'(error), FE_W'(0));

    $display("[TB] simultaneous requests");
    doReset();
    applyStimulus(2'b11, FE_W'(5), FE_W'(7), FE_W'(17), FE_W'(3));
    checkOutput("simul_busy", FE_W'(req_busy), FE_W'(2'b11));
    waitForDone("simul_timeout", 2, 80);
    repeat (3) @(negedge clk);
    checkOutput("simul_done0",  FE_W'(done_q[0]), FE_W'(2'b01));
    checkOutput("simul_res0",   res_q[0], FE_W'(35));
    checkOutput("simul_done1",  FE_W'(done_q[1]), FE_W'(2'b10));
    checkOutput("simul_res1",   res_q[1], FE_W'(51));
    checkOutput("simul_nvalid", FE_W'(valid_cnt), FE_W'(2));

    $display("[TB] fairness with immediate re-requests");
    doReset();
    applyStimulus(2'b11, FE_W'(2), FE_W'(3), FE_W'(4), FE_W'(5));
    seen = 0;
    for (int cyc = 0; cyc < 300 && seen < 4; cyc++) begin
      @(negedge clk);
      req_valid = '0;
      if (req_done != '0) begin
        seen++;
        if (seen <= 2) req_valid = req_done;
      end
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checkOutput("fair_count", FE_W'(done_q.size()), FE_W'(4));
    checkOutput("fair_g0",    FE_W'(done_q[0]), FE_W'(2'b01));
    checkOutput("fair_g1",    FE_W'(done_q[1]), FE_W'(2'b10));
    checkOutput("fair_g2",    FE_W'(done_q[2]), FE_W'(2'b01));
    checkOutput("fair_g3",    FE_W'(done_q[3]), FE_W'(2'b10));
    checkOutput("fair_r2",    res_q[2], FE_W'(6));
    checkOutput("fair_r3",    res_q[3], FE_W'(20));
    checkOutput("fair_error", FE_W'(error), FE_W'(0));

    $display("[TB] busy violation on port 1");
    clearLog();
    applyStimulus(2'b10, FE_W'(0), FE_W'(0), FE_W'(6), FE_W'(7));
    checkOutput("busy_flag", FE_W'(req_busy), FE_W'(2'b10));
    applyStimulus(2'b10, FE_W'(0), FE_W'(0), FE_W'(9), FE_W'(9));
    checkOutput("busy_error_rise", FE_W'(error), FE_W'(1));
    waitForDone("busy_timeout", 1, 50);
    repeat (20) @(negedge clk);
    checkOutput("busy_ndone",        FE_W'(done_q.size()), FE_W'(1));
    checkOutput("busy_done",         FE_W'(done_q[0]), FE_W'(2'b10));
    checkOutput("busy_res",          res_q[0], FE_W'(42));
    checkOutput("busy_error_sticky", FE_W'(error), FE_W'(1));

    $display("[TB] reset during WAIT");
    clearLog();
    applyStimulus(2'b01, FE_W'(8), FE_W'(8), FE_W'(0), FE_W'(0));
    for (int cyc = 0; cyc < 20 && !mul_bus.mul_valid; cyc++) @(negedge clk);
    checkOutput("wrst_issue", FE_W'(mul_bus.mul_valid), FE_W'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("wrst_busy",  FE_W'(req_busy), FE_W'(0));
    checkOutput("wrst_op_a",  mul_bus.mul_op_a, FE_W'(0));
    checkOutput("wrst_error", FE_W'(error), FE_W'(0));
    checkOutput("wrst_res",   req_res, FE_W'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearLog();
    repeat (10) @(negedge clk);
    checkOutput("wrst_no_done",  FE_W'(done_q.size()), FE_W'(0));
    checkOutput("wrst_no_valid", FE_W'(valid_cnt), FE_W'(0));
    applyStimulus(2'b10, FE_W'(0), FE_W'(0), FE_W'(3), FE_W'(3));
    waitForDone("wrst_timeout", 1, 50);
    repeat (2) @(negedge clk);
    checkOutput("wrst_new_done",  FE_W'(done_q[0]), FE_W'(2'b10));
    checkOutput("wrst_new_res",   res_q[0], FE_W'(9));
    checkOutput("wrst_new_error", FE_W'(error), FE_W'(0));

    $display("[TB] spurious mul_done in IDLE");
    clearLog();
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("spur_error",   FE_W'(error), FE_W'(1));
    checkOutput("spur_no_done", FE_W'(done_q.size()), FE_W'(0));
    checkOutput("spur_busy",    FE_W'(req_busy), FE_W'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
